// File: rtl/circle_buf_src_if.sv
// circle_buf_src_if: sample stream, capture control and buffer-side signals of circle_buf_src
// master: drives adc_in/adc_valid, decim, threshold, mode, arm, abort, auto_rearm, pretrig,
//         holdoff and full_flag; observes data_w, stb_w, trig_ext, trig_internal_ena, busy, drop_cnt
// slave : the producer itself (circle_buf_src), opposite directions
// CBSRC_TIMESTAMP_EN adds trig_ts[31:0] (slave output)
interface circle_buf_src_if #(
   parameter int dw = 16,
   parameter int cw = 8
);
   logic signed [dw-1:0] adc_in;
   logic                 adc_valid;
   logic [cw-1:0]        decim;
   logic signed [dw-1:0] threshold;
   logic [1:0]           mode;
   logic                 arm;
   logic                 abort;
   logic                 auto_rearm;
   logic [cw-1:0]        pretrig;
   logic [cw-1:0]        holdoff;
   logic                 full_flag;
   logic signed [dw-1:0] data_w;
   logic                 stb_w;
   logic                 trig_ext;
   logic                 trig_internal_ena;
   logic                 busy;
   logic [cw-1:0]        drop_cnt;
`ifdef CBSRC_TIMESTAMP_EN
   logic [31:0]          trig_ts;
   modport master (
      output adc_in, adc_valid, decim, threshold, mode, arm, abort, auto_rearm, pretrig, holdoff, full_flag,
      input  data_w, stb_w, trig_ext, trig_internal_ena, busy, drop_cnt, trig_ts
   );
   modport slave (
      input  adc_in, adc_valid, decim, threshold, mode, arm, abort, auto_rearm, pretrig, holdoff, full_flag,
      output data_w, stb_w, trig_ext, trig_internal_ena, busy, drop_cnt, trig_ts
   );
`else
   modport master (
      output adc_in, adc_valid, decim, threshold, mode, arm, abort, auto_rearm, pretrig, holdoff, full_flag,
      input  data_w, stb_w, trig_ext, trig_internal_ena, busy, drop_cnt
   );
   modport slave (
      input  adc_in, adc_valid, decim, threshold, mode, arm, abort, auto_rearm, pretrig, holdoff, full_flag,
      output data_w, stb_w, trig_ext, trig_internal_ena, busy, drop_cnt
   );
`endif
endinterface

// File: rtl/circle_buf_src.sv
// circle_buf_src: decimating, full-gated sample producer with threshold trigger for circle_buf4
// wclk  : write clock, rising edge
// reset : asynchronous, active-high
// bus   : circle_buf_src_if.slave (sample in, capture controls, full_flag in; data_w/stb_w,
//         trig_ext, trig_internal_ena, busy, drop_cnt out)
// CBSRC_TIMESTAMP_EN: adds trig_ts, the accepted-sample count latched at each trigger
module circle_buf_src #(
   parameter int dw = 16,
   parameter int cw = 8
) (
   input logic             wclk,
   input logic             reset,
   circle_buf_src_if.slave bus
);
   typedef enum logic [1:0] {IDLE, PRE, WAIT, HOLD} state_t;
   state_t               state_q, state_d;
   logic [cw-1:0]        dcnt_q, dcnt_d, pcnt_q, pcnt_d, hcnt_q, hcnt_d, drop_q, drop_d;
   logic signed [dw-1:0] data_q, data_d, prev_q, prev_d;
   logic                 stb_q, stb_d, trig_q, trig_d, pv_q, pv_d;
   logic                 keep, acc, rise, fall, hit, pre_done, hold_done;
`ifdef CBSRC_TIMESTAMP_EN
   logic [31:0]          ts_q, ts_d, trig_ts_q, trig_ts_d;
`endif
   always_comb begin
      keep      = bus.adc_valid && (dcnt_q == bus.decim);
      // a kept sample is accepted only if the buffer can take it; everything downstream counts acc
      acc       = keep && !bus.full_flag;
      dcnt_d    = !bus.adc_valid ? dcnt_q : keep ? '0 : dcnt_q + cw'(1);
      data_d    = acc ? bus.adc_in : data_q;
      stb_d     = acc;
      drop_d    = (keep && bus.full_flag && drop_q != '1) ? drop_q + cw'(1) : drop_q;
      rise      = pv_q && (prev_q < bus.threshold) && (bus.adc_in >= bus.threshold);
      fall      = pv_q && (prev_q > bus.threshold) && (bus.adc_in <= bus.threshold);
      hit       = bus.mode == 2'd3 || (bus.mode == 2'd1 && rise) || (bus.mode == 2'd2 && fall);
      prev_d    = acc ? bus.adc_in : prev_q;
      pv_d      = acc | pv_q;
      // leave PRE/HOLD on the sample that completes the count so no sample falls between phases
      pre_done  = pcnt_q == bus.pretrig || (acc && pcnt_q + cw'(1) == bus.pretrig);
      hold_done = hcnt_q == bus.holdoff || (acc && hcnt_q + cw'(1) == bus.holdoff);
      state_d   = state_q;
      pcnt_d    = pcnt_q;
      hcnt_d    = hcnt_q;
      trig_d    = 1'b0;
      case (state_q)
         IDLE: if (bus.arm && bus.mode != 2'd0) begin
            state_d = PRE;
            pcnt_d  = '0;
            pv_d    = 1'b0;
         end
         PRE: if (pre_done) state_d = WAIT;
              else if (acc) pcnt_d = pcnt_q + cw'(1);
         WAIT: if (acc && hit) begin
            trig_d  = 1'b1;
            state_d = HOLD;
            hcnt_d  = '0;
         end
         HOLD: if (hold_done) begin
            state_d = bus.auto_rearm ? PRE : IDLE;
            pcnt_d  = '0;
            pv_d    = bus.auto_rearm ? 1'b0 : pv_d;
         end else if (acc) hcnt_d = hcnt_q + cw'(1);
      endcase
      if (bus.abort) begin
         state_d = IDLE;
         trig_d  = 1'b0;
      end
`ifdef CBSRC_TIMESTAMP_EN
      ts_d      = acc ? ts_q + 32'd1 : ts_q;
      trig_ts_d = trig_d ? ts_q + 32'd1 : trig_ts_q;
`endif
   end
   always_ff @(posedge wclk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         dcnt_q    <= '0;
         pcnt_q    <= '0;
         hcnt_q    <= '0;
         drop_q    <= '0;
         data_q    <= '0;
         prev_q    <= '0;
         stb_q     <= 1'b0;
         trig_q    <= 1'b0;
         pv_q      <= 1'b0;
`ifdef CBSRC_TIMESTAMP_EN
         ts_q      <= '0;
         trig_ts_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         dcnt_q    <= dcnt_d;
         pcnt_q    <= pcnt_d;
         hcnt_q    <= hcnt_d;
         drop_q    <= drop_d;
         data_q    <= data_d;
         prev_q    <= prev_d;
         stb_q     <= stb_d;
         trig_q    <= trig_d;
         pv_q      <= pv_d;
`ifdef CBSRC_TIMESTAMP_EN
         ts_q      <= ts_d;
         trig_ts_q <= trig_ts_d;
`endif
      end
   end
   assign bus.data_w            = data_q;
   assign bus.stb_w             = stb_q;
   assign bus.trig_ext          = trig_q;
   assign bus.trig_internal_ena = bus.mode == 2'd0;
   assign bus.busy              = state_q != IDLE;
   assign bus.drop_cnt          = drop_q;
`ifdef CBSRC_TIMESTAMP_EN
   assign bus.trig_ts           = trig_ts_q;
`endif
endmodule
